// File: rtl/writeback_unit.sv
// Writeback stage: captures DECODE result words into a small FIFO and retires
// them one at a time as either a GPR write strobe or a granted RAM write.
module writeback_unit #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W+ADDR_W+3:0] complex_data,
    input  logic                     data_write,
    output logic                     pause_DECODE,
    output logic                     ram_wr,
    input  logic                     ram_garant_wr,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     GPR_wr,
    output logic [ADDR_W-1:0]        addr_GPRout,
    output logic [DATA_W-1:0]        data_GPRout,
    output logic                     err_opcode
);

    localparam int WORD_W = DATA_W + ADDR_W + 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [3:0] OP_MOV_SA  = 4'h1;
    localparam logic [3:0] OP_MOV_SR  = 4'h2;
    localparam logic [3:0] OP_MOV_BIO = 4'h3;
    localparam logic [3:0] OP_INC_SR  = 4'h4;
    localparam logic [3:0] OP_INC_BIO = 4'h5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GPR_WR  = 2'd1,
        S_RAM_REQ = 2'd2
    } state_e;

    function automatic logic op_is_ram(input logic [3:0] op);
        case (op)
            OP_MOV_SR, OP_INC_BIO: op_is_ram = 1'b1;
            default:               op_is_ram = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_gpr(input logic [3:0] op);
        case (op)
            OP_MOV_SA, OP_MOV_BIO, OP_INC_SR: op_is_gpr = 1'b1;
            default:                          op_is_gpr = 1'b0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                dw_q, dw_d;
    logic                pause_q, pause_d;
    logic                err_q, err_d;
    logic                gpr_wr_q, gpr_wr_d;
    logic                ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0]   gpr_addr_q, gpr_addr_d;
    logic [DATA_W-1:0]   gpr_data_q, gpr_data_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;

    logic                push_s, push_ok_s, pop_s, full_s, empty_s;
    logic [WORD_W-1:0]   head_s;
    logic [3:0]          head_op_s;
    logic [ADDR_W-1:0]   head_addr_s;
    logic [DATA_W-1:0]   head_data_s;

    assign head_s      = mem_q[rd_ptr_q];
    assign head_op_s   = head_s[3:0];
    assign head_addr_s = head_s[ADDR_W+3:4];
    assign head_data_s = head_s[WORD_W-1:ADDR_W+4];

    // Next-state logic for the retire FSM, FIFO bookkeeping and output registers.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dw_d       = data_write;
        err_d      = err_q;
        gpr_wr_d   = 1'b0;
        ram_wr_d   = ram_wr_q;
        gpr_addr_d = gpr_addr_q;
        gpr_data_d = gpr_data_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        pop_s      = 1'b0;
        full_s     = (count_q == CNT_W'(DEPTH));
        empty_s    = (count_q == CNT_W'(0));
        push_s     = data_write & ~dw_q;

        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (op_is_ram(head_op_s)) begin
                        ram_addr_d = head_addr_s;
                        ram_data_d = head_data_s;
                        ram_wr_d   = 1'b1;
                        state_d    = S_RAM_REQ;
                    end else if (op_is_gpr(head_op_s)) begin
                        gpr_addr_d = head_addr_s;
                        gpr_data_d = head_data_s;
                        gpr_wr_d   = 1'b1;
                        state_d    = S_GPR_WR;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GPR_WR: begin
                state_d = S_IDLE;
            end
            S_RAM_REQ: begin
                // Address/data stay frozen in ram_*_q until the grant retires the write.
                if (ram_garant_wr) begin
                    ram_wr_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    ram_wr_d = 1'b1;
                end
            end
            default: begin
                ram_wr_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        push_ok_s = push_s & ~full_s;
        if (push_s && full_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        pause_d = (count_d >= CNT_W'(DEPTH - 1));
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dw_q       <= 1'b0;
            pause_q    <= 1'b0;
            err_q      <= 1'b0;
            gpr_wr_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            gpr_addr_q <= '0;
            gpr_data_q <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dw_q       <= dw_d;
            pause_q    <= pause_d;
            err_q      <= err_d;
            gpr_wr_q   <= gpr_wr_d;
            ram_wr_q   <= ram_wr_d;
            gpr_addr_q <= gpr_addr_d;
            gpr_data_q <= gpr_data_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= complex_data;
        end
    end

    assign pause_DECODE = pause_q;
    assign ram_wr       = ram_wr_q;
    assign addr_out     = ram_wr_q ? ram_addr_q : {ADDR_W{1'bz}};
    assign data_out     = ram_wr_q ? ram_data_q : {DATA_W{1'bz}};
    assign GPR_wr       = gpr_wr_q;
    assign addr_GPRout  = gpr_addr_q;
    assign data_GPRout  = gpr_data_q;
    assign err_opcode   = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: scoreboard of expected writes plus
// a vector table and hand-written multi-cycle sequences.
module tb_writeback_unit;

    localparam logic [3:0] T_MOV_SA  = 4'h1;
    localparam logic [3:0] T_MOV_SR  = 4'h2;
    localparam logic [3:0] T_MOV_BIO = 4'h3;
    localparam logic [3:0] T_INC_SR  = 4'h4;
    localparam logic [3:0] T_INC_BIO = 4'h5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] complex_data = '0;
    logic        data_write = 1'b0;
    logic        pause_DECODE;
    logic        ram_wr;
    logic        ram_garant_wr = 1'b0;
    logic [11:0] addr_out;
    logic [13:0] data_out;
    logic        GPR_wr;
    logic [11:0] addr_GPRout;
    logic [13:0] data_GPRout;
    logic        err_opcode;

    writeback_unit #(.DATA_W(14), .ADDR_W(12), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .complex_data(complex_data), .data_write(data_write),
        .pause_DECODE(pause_DECODE), .ram_wr(ram_wr), .ram_garant_wr(ram_garant_wr),
        .addr_out(addr_out), .data_out(data_out), .GPR_wr(GPR_wr),
        .addr_GPRout(addr_GPRout), .data_GPRout(data_GPRout), .err_opcode(err_opcode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_ram;
        logic [11:0] addr;
        logic [13:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] addr;
        logic [13:0] data;
        int          gdelay;
        int          n_gpr;
        int          n_ram;
        logic        err;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gpr_cnt = 0;
    int   ram_cnt = 0;
    logic gpr_prev = 1'b0;
    logic ram_prev = 1'b0;
    logic [11:0] cur_addr = '0;
    logic [13:0] cur_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [3:0] op);
        case (op)
            T_MOV_SR, T_INC_BIO:             kind_of = 2;
            T_MOV_SA, T_MOV_BIO, T_INC_SR:   kind_of = 1;
            default:                         kind_of = 0;
        endcase
    endfunction

    // Output monitor: pops the scoreboard on every retired write
    always @(negedge clk) begin
        exp_t e;
        if (GPR_wr || ram_wr) check("no_overlap", {31'd0, GPR_wr & ram_wr}, 32'd0);
        if (GPR_wr) begin
            gpr_cnt++;
            check("gpr_pulse_1cyc", {31'd0, gpr_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                check("gpr_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("gpr_kind", {31'd0, e.is_ram}, 32'd0);
                check("gpr_addr", {20'd0, addr_GPRout}, {20'd0, e.addr});
                check("gpr_data", {18'd0, data_GPRout}, {18'd0, e.data});
            end
        end
        if (ram_wr && !ram_prev) begin
            ram_cnt++;
            cur_addr = addr_out;
            cur_data = data_out;
            if (sb_q.size() == 0) begin
                check("ram_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ram_kind", {31'd0, e.is_ram}, 32'd1);
                check("ram_addr", {20'd0, addr_out}, {20'd0, e.addr});
                check("ram_data", {18'd0, data_out}, {18'd0, e.data});
            end
        end else if (ram_wr && ram_prev) begin
            check("ram_addr_stable", {20'd0, addr_out}, {20'd0, cur_addr});
            check("ram_data_stable", {18'd0, data_out}, {18'd0, cur_data});
        end
        gpr_prev = GPR_wr;
        ram_prev = ram_wr;
    end

    task automatic drive_word(input logic [3:0] op, input logic [11:0] a, input logic [13:0] d);
        exp_t e;
        complex_data = {d, a, op};
        data_write = 1'b1;
        if (kind_of(op) != 0) begin
            e.is_ram = (kind_of(op) == 2);
            e.addr = a;
            e.data = d;
            sb_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [3:0] op, input logic [11:0] a, input logic [13:0] d, input int hold);
        @(posedge clk); #1;
        drive_word(op, a, d);
        repeat (hold) @(posedge clk);
        #1 data_write = 1'b0;
    endtask

    task automatic wait_ram(output logic found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ram_wr) found = 1'b1;
        end
        if (!found) check("ram_wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_ram_grant(input int delay);
        logic found;
        wait_ram(found);
        if (found) begin
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                check("ram_wr_held", {31'd0, ram_wr}, 32'd1);
            end
            ram_garant_wr = 1'b1;
            @(posedge clk); #1;
            ram_garant_wr = 1'b0;
            @(negedge clk);
            check("ram_wr_fall", {31'd0, ram_wr}, 32'd0);
        end
    endtask

    vec_t vecs[9];

    initial begin
        int g0, r0;
        logic found;

        vecs[0] = '{T_MOV_SA,  12'h010, 14'h0001, 0, 1, 0, 1'b0};
        vecs[1] = '{T_MOV_SR,  12'h020, 14'h0AAA, 0, 0, 1, 1'b0};
        vecs[2] = '{T_MOV_BIO, 12'h030, 14'h1555, 0, 1, 0, 1'b0};
        vecs[3] = '{T_INC_SR,  12'h000, 14'h0000, 0, 1, 0, 1'b0};
        vecs[4] = '{T_INC_BIO, 12'h5A5, 14'h2345, 2, 0, 1, 1'b0};
        vecs[5] = '{T_MOV_SR,  12'hFFF, 14'h3FFF, 1, 0, 1, 1'b0};
        vecs[6] = '{4'hF,      12'h123, 14'h0456, 0, 0, 0, 1'b1};
        vecs[7] = '{4'h0,      12'h124, 14'h0457, 0, 0, 0, 1'b1};
        vecs[8] = '{T_MOV_SA,  12'hABC, 14'h1234, 0, 1, 0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_gpr_wr", {31'd0, GPR_wr}, 32'd0);
        check("rst_pause", {31'd0, pause_DECODE}, 32'd0);
        check("rst_err", {31'd0, err_opcode}, 32'd0);
        check("rst_addr_gpr", {20'd0, addr_GPRout}, 32'd0);
        check("rst_data_gpr", {18'd0, data_GPRout}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Latency: push at edge N, pop at N+1, GPR_wr visible only in the cycle after N+1
        @(posedge clk); #1;
        drive_word(T_INC_SR, 12'h300, 14'h0123);
        @(posedge clk); #1 data_write = 1'b0;
        @(negedge clk);
        check("gpr_lat_early", {31'd0, GPR_wr}, 32'd0);
        @(negedge clk);
        check("gpr_lat_n2", {31'd0, GPR_wr}, 32'd1);
        @(negedge clk);
        check("gpr_lat_after", {31'd0, GPR_wr}, 32'd0);

        // Grant asserted while idle must not cause a write
        r0 = ram_cnt;
        @(negedge clk) ram_garant_wr = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_grant_no_wr", {31'd0, ram_wr}, 32'd0);
        ram_garant_wr = 1'b0;
        check("idle_grant_cnt", ram_cnt - r0, 32'd0);

        // RAM write with grant delayed five cycles
        send_word(T_MOV_SR, 12'h7E1, 14'h2BCD, 1);
        do_ram_grant(5);

        // Held data_write level is a single word
        g0 = gpr_cnt;
        send_word(T_MOV_BIO, 12'h044, 14'h0F0F, 6);
        repeat (4) @(negedge clk);
        check("held_level_one_wr", gpr_cnt - g0, 32'd1);
        check("held_level_sb", sb_q.size(), 32'd0);

        // Fill FIFO behind a stalled RAM write, then drain in order
        send_word(T_MOV_SR,  12'h101, 14'h0011, 1);
        send_word(T_INC_BIO, 12'h102, 14'h0022, 1);
        send_word(T_MOV_SR,  12'h103, 14'h0033, 1);
        @(negedge clk);
        check("pause_cnt2", {31'd0, pause_DECODE}, 32'd0);
        send_word(T_INC_BIO, 12'h104, 14'h0044, 1);
        @(negedge clk);
        check("pause_cnt3", {31'd0, pause_DECODE}, 32'd1);
        r0 = ram_cnt;
        do_ram_grant(0);
        @(negedge clk);
        check("pause_drop", {31'd0, pause_DECODE}, 32'd0);
        repeat (3) do_ram_grant(0);
        check("fill_drain_cnt", ram_cnt - r0, 32'd3);
        check("fill_drain_sb", sb_q.size(), 32'd0);

        for (int i = 0; i < 9; i++) begin
            g0 = gpr_cnt;
            r0 = ram_cnt;
            send_word(vecs[i].op, vecs[i].addr, vecs[i].data, 1);
            if (vecs[i].n_ram != 0) do_ram_grant(vecs[i].gdelay);
            else repeat (4) @(negedge clk);
            check($sformatf("vec%0d_gpr", i), gpr_cnt - g0, vecs[i].n_gpr);
            check($sformatf("vec%0d_ram", i), ram_cnt - r0, vecs[i].n_ram);
            check($sformatf("vec%0d_err", i), {31'd0, err_opcode}, {31'd0, vecs[i].err});
        end

        // Reset during an outstanding RAM request with words buffered
        send_word(T_MOV_SR, 12'h222, 14'h0222, 1);
        wait_ram(found);
        send_word(T_MOV_SR, 12'h223, 14'h0223, 1);
        send_word(T_MOV_SR, 12'h224, 14'h0224, 1);
        send_word(T_MOV_SR, 12'h225, 14'h0225, 1);
        @(negedge clk);
        check("pre_rst_pause", {31'd0, pause_DECODE}, 32'd1);
        check("pre_rst_ram_wr", {31'd0, ram_wr}, 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("rst_mid_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_mid_pause", {31'd0, pause_DECODE}, 32'd0);
        check("rst_mid_err", {31'd0, err_opcode}, 32'd0);
        r0 = ram_cnt;
        g0 = gpr_cnt;
        ram_garant_wr = 1'b1;
        repeat (5) @(negedge clk);
        ram_garant_wr = 1'b0;
        check("rst_discard_ram", ram_cnt - r0, 32'd0);
        check("rst_discard_gpr", gpr_cnt - g0, 32'd0);

        check("final_sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
